caf_peak_select: RTL and testbench
==================================

Name: caf_peak_select

Overview:
- Downstream of the per-frequency-bin argmax stage in the CAF chain.
- Consumes one (peak magnitude, delay index) result per Doppler bin and tracks the global maximum across FREQ_BINS bins.
- Emits a single (max, delay index, frequency bin) triple per CAF frame over an AXI-stream-style valid/ready handshake.

Parameters:
- MAX_BITS, 32, width of the argmax peak magnitude (unsigned).
- INDEX_BITS, 10, width of the argmax delay index.
- FREQ_BINS, 16, number of Doppler bins per frame; legal range is 1 and up.
- FREQ_BITS, derived as clog2(FREQ_BINS), minimum 1; localparam, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tvalid  in  1  upstream argmax result valid
- s_axis_tready  out  1  block can accept a bin result
- s_axis_max  in  MAX_BITS  peak magnitude for the current bin
- s_axis_index  in  INDEX_BITS  delay index of that peak
- m_axis_tvalid  out  1  frame result valid
- m_axis_tready  in  1  downstream accepts the result
- m_axis_max  out  MAX_BITS  global peak magnitude
- m_axis_index  out  INDEX_BITS  delay index of the global peak
- m_axis_freq  out  FREQ_BITS  bin number (0-based, arrival order) of the global peak

Behaviour:
- Reset is async assert, sync deassert. On reset:
  - state = ACCUM, bin count = 0, s_axis_tready = 0 during reset and 1 from the first clock after release.
  - m_axis_tvalid = 0; m_axis_max, m_axis_index and m_axis_freq = 0.
- FSM, two states:
  - ACCUM: s_axis_tready = 1. A beat is accepted when s_axis_tvalid and s_axis_tready are both high at the clock edge.
  - HOLD: s_axis_tready = 0, m_axis_tvalid = 1.
- Accepted beat with count = 0: unconditionally load max, index and freq = 0.
- Accepted beat with count > 0: load max, index and freq = count only if s_axis_max is strictly greater than the stored max (unsigned compare). Ties keep the earlier bin.
- Count increments on each accepted beat.
- When the accepted beat is bin FREQ_BINS-1:
  - Next state is HOLD and the count clears to 0.
  - m_axis_tvalid rises on the clock after that beat (latency 1 cycle); the triple already includes the final beat's comparison.
- HOLD:
  - The triple is held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - On a handshake, return to ACCUM and drop m_axis_tvalid next cycle.
  - m_axis_tready has no effect outside HOLD.
- Back-to-back frames: the first beat of the next frame can be accepted on the cycle after the output handshake (one bubble per frame).
- FREQ_BINS = 1: every accepted beat moves to HOLD; freq is always 0.
- Gaps: s_axis_tvalid may drop at any time; the count and stored values persist.
- Reset mid-frame: the partial frame is discarded; no output is produced for it.
- All outputs are registered; there are no combinational paths from input to output.

Optional Feature:
- Macro: CAF_PEAK_THRESH_EN.
- Defined:
  - Adds port threshold (in, MAX_BITS), sampled every cycle; must be held stable for the whole frame.
  - Adds port m_axis_detect (out, 1), registered alongside the triple: 1 when final max >= threshold, else 0.
  - m_axis_detect resets to 0 and is held stable in HOLD like the triple.
- Undefined: both ports are absent; behaviour is otherwise identical.

Decomposition:
- Shared package caf_pkg holds:
  - State encoding constants ACCUM=1'b0, HOLD=1'b1.
  - A clog2 width helper, used to derive FREQ_BITS.
- Sub-module caf_peak_cmp (one instance):
  - Holds the registered max, index and freq.
  - Inputs: load-unconditional, candidate max/index/freq, enable.
  - Contains the strict-greater compare.
- Top level holds the FSM, bin counter, handshake logic and the optional threshold compare.

Test Plan:
- FREQ_BINS=4, continuous valid, maxes 5,9,3,7 with indices 10,20,30,40 -> m_axis_tvalid rises 1 cycle after the 4th beat; max=9, index=20, freq=1.
- Tie: maxes 8,8,2,8 -> max=8, index from bin 0, freq=0.
- Backpressure: m_axis_tready=0 for 5 cycles in HOLD -> s_axis_tready=0 and outputs stable throughout. Then tready=1 -> one handshake; next frame of 1,2,3,4 gives max=4, freq=3.
- Gappy input: valid toggles 1,0,0,1,0,1,1 with maxes 0,0xFFFFFFFF,1,2 -> max=0xFFFFFFFF, freq=1; the unsigned compare also covers the MSB-set case.
- Reset mid-frame: rst_n low after 2 beats, then a fresh 4-beat frame of 1,1,1,6 -> exactly one result, max=6, freq=3; all outputs read 0 while rst_n is low.
- With CAF_PEAK_THRESH_EN, threshold=100: frame with max 100 -> detect=1; frame with max 99 -> detect=0.

Source files
------------

// File: rtl/caf_pkg.sv
// rtl/caf_pkg.sv - shared FSM encoding and width helper for the CAF peak selector
package caf_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } caf_state_t;

    // Bits needed to number `value` items, never less than one.
    function automatic int caf_clog2(input int value);
        int width;
        width = 1;
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) < value) begin
                width = w + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/caf_peak_cmp.sv
// rtl/caf_peak_cmp.sv - registered running maximum with strict-greater update
module caf_peak_cmp #(
    parameter int MAX_BITS   = 32,
    parameter int INDEX_BITS = 10,
    parameter int FREQ_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [MAX_BITS-1:0]   cand_max,
    input  logic [INDEX_BITS-1:0] cand_index,
    input  logic [FREQ_BITS-1:0]  cand_freq,
    output logic [MAX_BITS-1:0]   peak_max,
    output logic [INDEX_BITS-1:0] peak_index,
    output logic [FREQ_BITS-1:0]  peak_freq
);

    logic take;

    // Ties never replace, so the earliest bin with the peak value wins.
    assign take = en && (load || (cand_max > peak_max));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_max   <= '0;
            peak_index <= '0;
            peak_freq  <= '0;
        end else if (take) begin
            peak_max   <= cand_max;
            peak_index <= cand_index;
            peak_freq  <= cand_freq;
        end
    end

endmodule

// File: rtl/caf_peak_select.sv
// rtl/caf_peak_select.sv - global CAF peak across Doppler bins; CAF_PEAK_THRESH_EN adds threshold/detect
module caf_peak_select
    import caf_pkg::*;
#(
    parameter int MAX_BITS   = 32,
    parameter int INDEX_BITS = 10,
    parameter int FREQ_BINS  = 16,
    localparam int FREQ_BITS = caf_clog2(FREQ_BINS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [MAX_BITS-1:0]   s_axis_max,
    input  logic [INDEX_BITS-1:0] s_axis_index,
`ifdef CAF_PEAK_THRESH_EN
    input  logic [MAX_BITS-1:0]   threshold,
    output logic                  m_axis_detect,
`endif
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [MAX_BITS-1:0]   m_axis_max,
    output logic [INDEX_BITS-1:0] m_axis_index,
    output logic [FREQ_BITS-1:0]  m_axis_freq
);

    localparam logic [FREQ_BITS-1:0] LAST_BIN = FREQ_BITS'(FREQ_BINS - 1);

    caf_state_t           state;
    caf_state_t           next_state;
    logic [FREQ_BITS-1:0] count;
    logic                 tready_q;
    logic                 accept;
    logic                 last;

    assign accept        = s_axis_tvalid && tready_q;
    assign last          = (count == LAST_BIN);
    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = (state == HOLD);

    always_comb begin
        next_state = state;
        case (state)
            ACCUM:   if (accept && last) next_state = HOLD;
            HOLD:    if (m_axis_tready)  next_state = ACCUM;
            default: next_state = ACCUM;
        endcase
    end

    // Ready is a flop so it stays low while reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACCUM;
            count    <= '0;
            tready_q <= 1'b0;
        end else begin
            state    <= next_state;
            tready_q <= (next_state == ACCUM);
            if (accept) begin
                count <= last ? '0 : count + 1'b1;
            end
        end
    end

    caf_peak_cmp #(
        .MAX_BITS   (MAX_BITS),
        .INDEX_BITS (INDEX_BITS),
        .FREQ_BITS  (FREQ_BITS)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (accept),
        .load       (count == '0),
        .cand_max   (s_axis_max),
        .cand_index (s_axis_index),
        .cand_freq  (count),
        .peak_max   (m_axis_max),
        .peak_index (m_axis_index),
        .peak_freq  (m_axis_freq)
    );

`ifdef CAF_PEAK_THRESH_EN
    logic [MAX_BITS-1:0] final_max;
    logic                detect_q;

    // Frame maximum as it will stand after the final beat is folded in.
    assign final_max = ((count == '0) || (s_axis_max > m_axis_max)) ? s_axis_max : m_axis_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            detect_q <= 1'b0;
        end else if (accept && last) begin
            detect_q <= (final_max >= threshold);
        end
    end

    assign m_axis_detect = detect_q;
`endif

endmodule

// File: tb/tb_caf_peak_select.sv
// tb/tb_caf_peak_select.sv - self-checking bench for caf_peak_select (FREQ_BINS=4)
module tb_caf_peak_select;

    localparam int MB = 32;
    localparam int IB = 10;
    localparam int NB = 4;
    localparam int FB = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [MB-1:0] s_axis_max = '0;
    logic [IB-1:0] s_axis_index = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [MB-1:0] m_axis_max;
    logic [IB-1:0] m_axis_index;
    logic [FB-1:0] m_axis_freq;
`ifdef CAF_PEAK_THRESH_EN
    logic [MB-1:0] threshold = 32'd100;
    logic          m_axis_detect;
`endif

    caf_peak_select #(
        .MAX_BITS   (MB),
        .INDEX_BITS (IB),
        .FREQ_BINS  (NB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_max    (s_axis_max),
        .s_axis_index  (s_axis_index),
`ifdef CAF_PEAK_THRESH_EN
        .threshold     (threshold),
        .m_axis_detect (m_axis_detect),
`endif
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_max    (m_axis_max),
        .m_axis_index  (m_axis_index),
        .m_axis_freq   (m_axis_freq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NB-1:0][MB-1:0] mx;
        logic [NB-1:0][IB-1:0] ix;
        int                    gap [NB];
        logic [MB-1:0]         e_max;
        logic [IB-1:0]         e_idx;
        logic [FB-1:0]         e_freq;
        logic                  e_det;
    } frame_t;

    typedef struct {
        logic [MB-1:0] mx;
        logic [IB-1:0] ix;
        logic [FB-1:0] fr;
        logic          det;
    } exp_t;

    frame_t tbl[$];
    exp_t   sb[$];
    exp_t   got;
    int     checks = 0;
    int     errors = 0;
    int     results = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic add_frame(input logic [MB-1:0] m0, m1, m2, m3,
                             input logic [IB-1:0] i0, i1, i2, i3,
                             input int g0, g1, g2, g3,
                             input logic [MB-1:0] em, input logic [IB-1:0] ei,
                             input logic [FB-1:0] ef, input logic ed);
        frame_t f;
        f.mx[0] = m0; f.mx[1] = m1; f.mx[2] = m2; f.mx[3] = m3;
        f.ix[0] = i0; f.ix[1] = i1; f.ix[2] = i2; f.ix[3] = i3;
        f.gap[0] = g0; f.gap[1] = g1; f.gap[2] = g2; f.gap[3] = g3;
        f.e_max = em; f.e_idx = ei; f.e_freq = ef; f.e_det = ed;
        tbl.push_back(f);
    endtask

    task automatic expect_result(input logic [MB-1:0] m, input logic [IB-1:0] i,
                                 input logic [FB-1:0] fr, input logic d);
        exp_t e;
        e.mx = m; e.ix = i; e.fr = fr; e.det = d;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the beat is accepted.
    task automatic send(input logic [MB-1:0] m, input logic [IB-1:0] i);
        bit done;
        done = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_max    = m;
        s_axis_index  = i;
        for (int k = 0; k < 64 && !done; k++) begin
            done = s_axis_tready;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=0 required=1");
        end
    endtask

    task automatic run_frame(input frame_t f);
        expect_result(f.e_max, f.e_idx, f.e_freq, f.e_det);
        for (int b = 0; b < NB; b++) begin
            idle(f.gap[b]);
            send(f.mx[b], f.ix[b]);
            if (b == NB - 2) check("tvalid_before_last", m_axis_tvalid, 0);
        end
        check("tvalid_after_last", m_axis_tvalid, 1);
        check("sready_in_hold", s_axis_tready, 0);
    endtask

    always @(negedge clk) begin
        #2;
        if (rst_n && m_axis_tvalid && m_axis_tready) begin
            results++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h required=none", m_axis_max);
            end else begin
                got = sb.pop_front();
                check("res_max", m_axis_max, got.mx);
                check("res_index", m_axis_index, got.ix);
                check("res_freq", m_axis_freq, got.fr);
`ifdef CAF_PEAK_THRESH_EN
                check("res_detect", m_axis_detect, got.det);
`endif
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sready"}, s_axis_tready, 0);
        check({tag, "_tvalid"}, m_axis_tvalid, 0);
        check({tag, "_max"}, m_axis_max, 0);
        check({tag, "_index"}, m_axis_index, 0);
        check({tag, "_freq"}, m_axis_freq, 0);
`ifdef CAF_PEAK_THRESH_EN
        check({tag, "_detect"}, m_axis_detect, 0);
`endif
    endtask

    initial begin
        int r0;
        add_frame(5, 9, 3, 7, 10, 20, 30, 40, 0, 0, 0, 0, 9, 20, 1, 0);
        add_frame(8, 8, 2, 8, 1, 2, 3, 4, 0, 0, 0, 0, 8, 1, 0, 0);
        add_frame(0, 32'hFFFF_FFFF, 1, 2, 5, 6, 7, 8, 0, 2, 1, 0, 32'hFFFF_FFFF, 6, 1, 1);
        add_frame(100, 50, 20, 10, 11, 12, 13, 14, 0, 0, 0, 0, 100, 11, 0, 1);
        add_frame(99, 3, 99, 98, 51, 52, 53, 54, 0, 1, 0, 0, 99, 51, 0, 0);
        add_frame(32'h7FFF_FFFF, 32'h8000_0000, 1, 32'h8000_0000, 41, 42, 43, 44,
                  0, 0, 0, 0, 32'h8000_0000, 42, 1, 1);

        #1;
        check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("sready_at_release", s_axis_tready, 0);
        @(negedge clk);
        check("sready_after_release", s_axis_tready, 1);

        foreach (tbl[n]) run_frame(tbl[n]);
        idle(3);
        check("table_drained", sb.size(), 0);
        check("table_results", results, tbl.size());

        // Backpressure: result held, next beat waits, then exactly one handshake.
        r0 = results;
        m_axis_tready = 1'b0;
        expect_result(40, 4, 3, 0);
        send(10, 1); send(20, 2); send(30, 3); send(40, 4);
        s_axis_tvalid = 1'b1;
        s_axis_max    = 1;
        s_axis_index  = 21;
        for (int c = 0; c < 5; c++) begin
            check("bp_tvalid", m_axis_tvalid, 1);
            check("bp_sready", s_axis_tready, 0);
            check("bp_max", m_axis_max, 40);
            check("bp_index", m_axis_index, 4);
            check("bp_freq", m_axis_freq, 3);
            @(negedge clk);
        end
        check("bp_no_result", results - r0, 0);
        m_axis_tready = 1'b1;
        expect_result(4, 24, 3, 0);
        send(1, 21); send(2, 22); send(3, 23); send(4, 24);
        idle(3);
        check("bp_results", results - r0, 2);

        // Reset mid-frame discards the partial frame.
        r0 = results;
        send(50, 1); send(60, 2);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        expect_result(6, 34, 3, 0);
        send(1, 31); send(1, 32); send(1, 33); send(6, 34);
        idle(3);
        check("reset_results", results - r0, 1);
        check("final_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
